// File: rtl/hiscore_ram_port.sv
// hiscore_ram_port
//   Arbitrates a synchronous single-port work RAM between the CPU and a
//   hiscore save/restore engine. The CPU owns the RAM by default. The
//   hiscore side may take it only while the CPU is paused. One settle
//   cycle separates the two owners.
//
// Ports
//   clk_sys, reset_n           system clock, async active-low reset
//   pause                      CPU halted
//   hs_access                  hiscore side requests the RAM
//   hs_address / hs_data_in    hiscore byte address / write data
//   hs_write                   one-cycle hiscore write strobe
//   hs_data_out                registered read data (8'hFF if out of range)
//   hs_granted                 hiscore side owns the RAM
//   cpu_addr/cpu_dout/cpu_we/cpu_cs/cpu_din   CPU work-RAM port
//   ram_addr/ram_wdata/ram_we/ram_rdata       RAM port (1-cycle read latency)
module hiscore_ram_port #(
  parameter logic [15:0] RAM_BASE = 16'h6000,
  parameter int unsigned RAM_AW   = 11
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pause,
  input  logic              hs_access,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_granted,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_we,
  input  logic              cpu_cs,
  output logic [7:0]        cpu_din,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAITP  = 3'd1,
    SETTLE = 3'd2,
    READY  = 3'd3,
    WRITE  = 3'd4
  } state_t;

  localparam logic [16:0] BASE17 = {1'b0, RAM_BASE};
  localparam logic [16:0] TOP17  = BASE17 + (17'd1 << RAM_AW);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  rst_sync;
  logic        rst_ok;
  logic        we_ok;
  logic        in_range;
  logic        range_q;
  logic        hs_side;
  logic [15:0] hs_offset;
  logic        unused_bits;

  // Release is synchronised: CPU writes are enabled from the first edge
  // after release, FSM transitions from the second.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign we_ok  = rst_sync[0];
  assign rst_ok = rst_sync[1];

  // 17-bit compare so a window ending at 16'hFFFF cannot wrap.
  assign in_range  = ({1'b0, hs_address} >= BASE17) && ({1'b0, hs_address} < TOP17);
  assign hs_offset = hs_address - RAM_BASE;
  assign hs_side   = (state == SETTLE) || (state == READY) || (state == WRITE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (rst_ok && hs_access) state_nx = pause ? SETTLE : WAITP;
      WAITP:  if (!hs_access) state_nx = IDLE;
              else if (pause) state_nx = SETTLE;
      // Losing pause or access during settle also returns ownership.
      SETTLE: state_nx = (hs_access && pause) ? READY : IDLE;
      READY:  if (!hs_access || !pause) state_nx = IDLE;
              else if (hs_write && in_range) state_nx = WRITE;
      WRITE:  state_nx = (hs_access && pause) ? READY : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      range_q     <= 1'b0;
      hs_data_out <= '0;
    end else begin
      // range_q tracks the address whose data appears on ram_rdata now.
      range_q <= in_range;
      if (state == READY) hs_data_out <= range_q ? ram_rdata : 8'hFF;
    end
  end

  always_comb begin
    ram_we = 1'b0;
    case (state)
      IDLE, WAITP: ram_we = we_ok & cpu_cs & cpu_we;
      // Pause dropping mid-write hands the RAM back to the CPU untouched.
      WRITE:       ram_we = pause;
      default:     ram_we = 1'b0;
    endcase
  end

  assign ram_addr    = hs_side ? hs_offset[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];
  assign ram_wdata   = hs_side ? hs_data_in : cpu_dout;
  assign cpu_din     = ram_rdata;
  assign hs_granted  = (state == READY) || (state == WRITE);
  assign unused_bits = ^{cpu_addr, hs_offset};

endmodule

// File: tb/tb_hiscore_ram_port.sv
// tb_hiscore_ram_port
//   Directed sequence with random data/addresses for hiscore_ram_port.
//   A behavioural RAM sits on the RAM port; expected contents are kept in
//   a separate byte array updated from the access rules.
`timescale 1ns/1ps
module tb_hiscore_ram_port;

  logic        clk_sys;
  logic        reset_n;
  logic        pause;
  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic        hs_granted;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_cs;
  logic [7:0]  cpu_din;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int checks;
  int errors;

  logic [7:0]  mem     [0:2047];
  logic [7:0]  exp_mem [0:2047];
  logic [15:0] rq[$];
  logic [7:0]  d;
  logic [15:0] wa;
  int          n;

  hiscore_ram_port #(.RAM_BASE(16'h6000), .RAM_AW(11)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pause(pause), .hs_access(hs_access),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
    .hs_data_out(hs_data_out), .hs_granted(hs_granted), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_cs(cpu_cs), .cpu_din(cpu_din),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic bit tb_in_range(input logic [15:0] a);
    int unsigned v;
    v = 32'(a);
    return (v >= 32'h6000) && (v < 32'h6000 + 32'd2048);
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    int unsigned v;
    v = 32'(a);
    if (tb_in_range(a)) return exp_mem[11'(v - 32'h6000)];
    return 8'hFF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpu_read(input int unsigned a);
    cyc();
    cpu_cs   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'(32'h6000 + a);
    cyc();
    @(negedge clk_sys);
    chk($sformatf("cpu_rd_%0h", a), 32'(cpu_din), 32'(exp_mem[11'(a)]));
  endtask

  // Pipelined reads: data for the address applied in cycle k is due in k+2.
  task automatic hs_read_burst();
    int len;
    len = rq.size();
    for (int k = 0; k < len + 2; k++) begin
      cyc();
      if (k < len) hs_address = rq[k];
      @(negedge clk_sys);
      if (k >= 2)
        chk($sformatf("hs_rd_%h", rq[k-2]), 32'(hs_data_out), 32'(ref_read(rq[k-2])));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; pause = 1'b0; hs_access = 1'b0; hs_address = '0;
    hs_data_in = '0; hs_write = 1'b0; cpu_addr = 16'h6000; cpu_dout = '0;
    cpu_we = 1'b1; cpu_cs = 1'b1;

    // Reset state, with a CPU write request held throughout.
    repeat (3) cyc();
    @(negedge clk_sys);
    chk("rst_we", 32'(ram_we), 32'(1'b0));
    chk("rst_granted", 32'(hs_granted), 32'(1'b0));
    chk("rst_dout", 32'(hs_data_out), 32'h00);

    // Release: ram_we held until first edge, FSM held past the second.
    cyc();
    reset_n = 1'b1; hs_access = 1'b1; pause = 1'b1;
    @(negedge clk_sys);
    chk("rel_we_hold", 32'(ram_we), 32'(1'b0));
    cyc();
    @(negedge clk_sys);
    chk("rel_we_e1", 32'(ram_we), 32'(1'b1));
    chk("rel_gr_e1", 32'(hs_granted), 32'(1'b0));
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
    chk("rel_gr_e2", 32'(hs_granted), 32'(1'b0));
    cyc();
    @(negedge clk_sys);
    chk("rel_gr_e3", 32'(hs_granted), 32'(1'b0));
    n = 0;
    while (!hs_granted && n < 8) begin cyc(); n++; end
    chk("rel_grant", 32'(hs_granted), 32'(1'b1));
    cyc();
    hs_access = 1'b0; pause = 1'b0;
    cyc();
    @(negedge clk_sys);
    chk("drop_idle", 32'(hs_granted), 32'(1'b0));

    // Fill RAM through the CPU port with random data.
    for (int i = 0; i < 2048; i++) begin
      cyc();
      d = 8'($urandom);
      if (i == 2047) d = 8'h3C;
      cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'(32'h6000 + i); cpu_dout = d;
      exp_mem[i] = d;
      if (i < 3 || i == 2047) begin
        @(negedge clk_sys);
        chk($sformatf("fill_we_%0d", i), 32'(ram_we), 32'(1'b1));
        chk($sformatf("fill_addr_%0d", i), 32'(ram_addr), 32'(i));
      end
    end

    // CPU write then readback.
    cyc();
    cpu_addr = 16'h6005; cpu_dout = 8'hA5; exp_mem[5] = 8'hA5;
    @(negedge clk_sys);
    chk("cpu_wr_we", 32'(ram_we), 32'(1'b1));
    chk("cpu_wr_addr", 32'(ram_addr), 32'h005);
    cyc();
    cpu_we = 1'b0;
    cyc();
    @(negedge clk_sys);
    chk("cpu_rd_a5", 32'(cpu_din), 32'hA5);
    for (int i = 0; i < 12; i++) cpu_read($urandom_range(0, 2047));

    // Grant sequence: no grant while CPU runs, then exactly two cycles.
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0; hs_access = 1'b1; pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      @(negedge clk_sys);
      chk($sformatf("waitp_%0d", i), 32'(hs_granted), 32'(1'b0));
    end
    cyc();
    pause = 1'b1;
    @(negedge clk_sys);
    chk("pause_c0", 32'(hs_granted), 32'(1'b0));
    cyc();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6030; cpu_dout = ~exp_mem[11'h030];
    hs_write = 1'b1; hs_address = 16'h6040; hs_data_in = ~exp_mem[11'h040];
    @(negedge clk_sys);
    chk("settle_gr", 32'(hs_granted), 32'(1'b0));
    chk("settle_we", 32'(ram_we), 32'(1'b0));
    chk("settle_addr", 32'(ram_addr), 32'h040);
    cyc();
    hs_write = 1'b0;
    @(negedge clk_sys);
    chk("ready_gr", 32'(hs_granted), 32'(1'b1));
    chk("ready_cpu_blk", 32'(ram_we), 32'(1'b0));
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
    chk("no_queued_wr", 32'(ram_we), 32'(1'b0));

    // Granted read of the top byte.
    cyc();
    hs_address = 16'h67FF;
    @(negedge clk_sys);
    chk("rd_addr_7ff", 32'(ram_addr), 32'h7FF);
    cyc();
    cyc();
    @(negedge clk_sys);
    chk("rd_3c", 32'(hs_data_out), 32'h3C);

    // Boundary and random reads.
    rq = '{16'h5FFF, 16'h6000, 16'h67FF, 16'h6800, 16'hFFFF, 16'h0000, 16'h6030, 16'h6040};
    for (int i = 0; i < 20; i++)
      rq.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(32'h6000 + $urandom_range(0, 2047)));
    hs_read_burst();

    // Granted write: exactly one ram_we cycle.
    cyc();
    hs_address = 16'h6010; hs_data_in = 8'h5A; hs_write = 1'b1;
    @(negedge clk_sys);
    chk("w_ready_we", 32'(ram_we), 32'(1'b0));
    cyc();
    hs_write = 1'b0;
    @(negedge clk_sys);
    chk("w_we", 32'(ram_we), 32'(1'b1));
    chk("w_addr", 32'(ram_addr), 32'h010);
    chk("w_data", 32'(ram_wdata), 32'h5A);
    exp_mem[11'h010] = 8'h5A;
    cyc();
    @(negedge clk_sys);
    chk("w_once", 32'(ram_we), 32'(1'b0));
    cyc();
    cyc();
    @(negedge clk_sys);
    chk("w_readback", 32'(hs_data_out), 32'h5A);

    // Out-of-range write ignored, read gives FF.
    cyc();
    hs_address = 16'h6800; hs_data_in = 8'($urandom); hs_write = 1'b1;
    cyc();
    hs_write = 1'b0;
    @(negedge clk_sys);
    chk("oor_we", 32'(ram_we), 32'(1'b0));
    chk("oor_gr", 32'(hs_granted), 32'(1'b1));
    cyc();
    @(negedge clk_sys);
    chk("oor_ff", 32'(hs_data_out), 32'hFF);

    // Random writes, then read them back.
    rq.delete();
    for (int i = 0; i < 16; i++) begin
      wa = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'(32'h6000 + $urandom_range(0, 2047));
      d  = 8'($urandom);
      cyc();
      hs_address = wa; hs_data_in = d; hs_write = 1'b1;
      cyc();
      hs_write = 1'b0;
      @(negedge clk_sys);
      chk($sformatf("rw_we_%h", wa), 32'(ram_we), 32'(tb_in_range(wa)));
      if (tb_in_range(wa)) exp_mem[11'(32'(wa) - 32'h6000)] = d;
      rq.push_back(wa);
      cyc();
    end
    hs_read_burst();

    // Pause drops during WRITE: write discarded, back to IDLE.
    cyc();
    hs_address = 16'h6020; hs_data_in = ~exp_mem[11'h020]; hs_write = 1'b1;
    cyc();
    hs_write = 1'b0; pause = 1'b0;
    @(negedge clk_sys);
    chk("abort_we", 32'(ram_we), 32'(1'b0));
    cyc();
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h6020;
    @(negedge clk_sys);
    chk("abort_idle", 32'(hs_granted), 32'(1'b0));
    cyc();
    @(negedge clk_sys);
    chk("abort_ram", 32'(cpu_din), 32'(exp_mem[11'h020]));
    cyc();
    hs_access = 1'b0; cpu_cs = 1'b0;

    // Request while a CPU write is in progress: CPU write completes.
    cyc();
    d = 8'($urandom);
    hs_access = 1'b1; pause = 1'b1; hs_address = 16'h6060;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6050; cpu_dout = d;
    exp_mem[11'h050] = d;
    @(negedge clk_sys);
    chk("r18_cpu_we", 32'(ram_we), 32'(1'b1));
    chk("r18_cpu_addr", 32'(ram_addr), 32'h050);
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
    chk("r18_settle_gr", 32'(hs_granted), 32'(1'b0));
    chk("r18_settle_we", 32'(ram_we), 32'(1'b0));
    cyc();
    @(negedge clk_sys);
    chk("r18_ready", 32'(hs_granted), 32'(1'b1));

    // Access drops during WRITE: that write still lands.
    cyc();
    d = 8'($urandom);
    hs_data_in = d; hs_write = 1'b1;
    cyc();
    hs_write = 1'b0; hs_access = 1'b0;
    @(negedge clk_sys);
    chk("drop_w_we", 32'(ram_we), 32'(1'b1));
    exp_mem[11'h060] = d;
    cyc();
    @(negedge clk_sys);
    chk("drop_w_idle", 32'(hs_granted), 32'(1'b0));
    cpu_read(32'h050);
    cpu_read(32'h060);

    // Asynchronous reset in the middle of READY.
    cyc();
    cpu_cs = 1'b0; hs_access = 1'b1; pause = 1'b1; hs_address = 16'h67FF;
    repeat (3) cyc();
    cyc();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6070; cpu_dout = 8'($urandom);
    @(negedge clk_sys);
    chk("pre_rst_dout", 32'(hs_data_out), 32'h3C);
    chk("pre_rst_gr", 32'(hs_granted), 32'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("arst_gr", 32'(hs_granted), 32'(1'b0));
    chk("arst_dout", 32'(hs_data_out), 32'h00);
    chk("arst_we", 32'(ram_we), 32'(1'b0));
    cyc();
    cpu_cs = 1'b0; cpu_we = 1'b0; hs_access = 1'b0;
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    cpu_read(32'h7FF);
    cpu_read(32'h010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_port.md
HISCORE_RAM_PORT -- requirements
Module: hiscore_ram_port

Interface
REQ-001 Parameter RAM_BASE, default 16'h6000: CPU/hiscore address of work-RAM byte 0.
REQ-002 Parameter RAM_AW, default 11: work-RAM address width (2 KiB).
REQ-003 Ports, clock and reset first:
- clk_sys  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- pause  in  1  CPU halted; only then may the hiscore side own the RAM.
- hs_access  in  1  hiscore side requests RAM ownership.
- hs_address  in  16  hiscore byte address.
- hs_data_in  in  8  write data from hiscore.
- hs_write  in  1  one-cycle write strobe.
- hs_data_out  out  8  read data to hiscore.
- hs_granted  out  1  hiscore side owns RAM.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_we  in  1  CPU write enable, qualified by cpu_cs.
- cpu_cs  in  1  CPU selects work RAM.
- cpu_din  out  8  RAM read data to CPU.
- ram_addr  out  RAM_AW  synchronous single-port RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  8  RAM read data, one-cycle latency.

Function
REQ-004 FSM states: IDLE, WAITP, SETTLE, READY, WRITE.
REQ-005 IDLE: CPU owns RAM; ram_addr = cpu_addr[RAM_AW-1:0]; ram_wdata = cpu_dout; ram_we = cpu_cs & cpu_we; cpu_din = ram_rdata.
REQ-006 IDLE -> WAITP when hs_access=1 and pause=0; IDLE -> SETTLE when hs_access=1 and pause=1.
REQ-007 WAITP -> SETTLE when pause=1; WAITP -> IDLE when hs_access drops.
REQ-008 SETTLE lasts exactly one cycle with ram_we=0 and the mux switched to hiscore, then -> READY.
REQ-009 In SETTLE, READY and WRITE: ram_addr = hs_address - RAM_BASE, truncated to RAM_AW bits; ram_wdata = hs_data_in; CPU writes are blocked.
REQ-010 hs_granted = 1 only in READY and WRITE.
REQ-011 In READY, hs_data_out is registered each cycle from ram_rdata, so data for an address stable in cycle N is valid at cycle N+2.
REQ-012 In READY, hs_write=1 with hs_address in range -> WRITE; ram_we=1 for exactly one cycle in WRITE, then -> READY.
REQ-013 In range means RAM_BASE <= hs_address < RAM_BASE + 2^RAM_AW, using a 17-bit comparison with no wrap.
REQ-014 Out-of-range addresses: hs_data_out = 8'hFF; hs_write is ignored and the FSM stays in READY.
REQ-015 hs_write asserted outside READY is ignored and not queued.
REQ-016 hs_access dropping in READY or WRITE -> IDLE next cycle; a write already in WRITE completes that same cycle.
REQ-017 pause dropping while granted forces -> IDLE next cycle with ram_we=0 (CPU priority), even mid-WRITE; the pending write is discarded.
REQ-018 hs_access=1 with pause=1 arriving while cpu_cs=1 in IDLE still -> SETTLE; the CPU access in that cycle completes normally.
REQ-019 ram_we is registered-state based and never glitches across an ownership change.

Reset
REQ-020 reset_n=0 asynchronously forces IDLE, hs_granted=0, hs_data_out=8'h00 and ram_we=0; ram_we stays 0 until the first clock edge after release.
REQ-021 Reset release is synchronised so the FSM leaves IDLE no earlier than the second clk_sys edge after reset_n rises.

Verification
REQ-022 CPU write, then readback: cpu_cs=1, cpu_we=1, cpu_addr=16'h6005, cpu_dout=8'hA5 -> ram_we=1, ram_addr=11'h005; a read of the same address gives cpu_din=8'hA5 one cycle later.
REQ-023 Grant sequence: hs_access=1, pause=0 for 5 cycles -> hs_granted=0 throughout; then pause=1 -> hs_granted=1 exactly 2 cycles later (SETTLE, then READY).
REQ-024 Granted read: preload RAM[0x7FF]=8'h3C, hs_address=16'h67FF -> hs_data_out=8'h3C two cycles after the address is applied.
REQ-025 Granted write: hs_address=16'h6010, hs_data_in=8'h5A, hs_write pulse -> exactly one ram_we cycle at ram_addr=11'h010; hs_address=16'h6800 -> ram_we=0 and hs_data_out=8'hFF.
REQ-026 Abort cases:
- pause drops in the WRITE cycle -> ram_we=0 and IDLE next cycle; RAM is unchanged.
- reset_n pulsed low mid-READY -> outputs take reset values immediately, without waiting for a clock edge.
